uart_rx_path: RTL and testbench

- Receive half of the APB UART: programmable 16x baud-tick generator, 2-FF input synchronizer, 8N1 oversampling deserializer and a show-ahead receive FIFO.
- The APB wrapper drives `divisor` from its baud register, pops bytes with `rd_en`, and reads `rd_data` and `empty` in the same access (zero wait state).

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/uart_rx_path.sv | 135 +++++++++++++
 tb/tb_uart_rx_path.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DEFAULT_DIVISOR = 325;
  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned MID_START       = 7;
  localparam int unsigned TICK_CNT_W      = 4;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; head is visible on rd_data_o without a pop.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overrun_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("byte_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overrun_q;
  logic             wr_ok, rd_ok;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign overrun_o = overrun_q;

  // Accept decisions use the flags as they stand before the edge.
  assign wr_ok = wr_en_i & ~full_o;
  assign rd_ok = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= wr_en_i & full_o;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: 16x baud tick, 2-FF synchronizer, 8N1 oversampling receiver, byte FIFO.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic [DIV_WIDTH-1:0]    divisor,
  input  logic                    rx_i,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    tick_16x,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d, baud_last;
  logic                  sync1_q, sync2_q;
  rx_state_e             state_q;
  logic [TICK_CNT_W-1:0] s_q;
  logic [NW-1:0]         n_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  rx_wr_q;
  logic                  frame_err_q;

  // Divisors of 0 and 1 both collapse to a tick on every cycle.
  assign baud_last  = (divisor <= DIV_WIDTH'(1)) ? '0 : divisor - DIV_WIDTH'(1);
  assign tick_16x   = (baud_cnt_q == baud_last);
  assign baud_cnt_d = (baud_cnt_q >= baud_last) ? '0 : baud_cnt_q + DIV_WIDTH'(1);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) baud_cnt_q <= '0;
    else        baud_cnt_q <= baud_cnt_d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Receiver: start qualified at mid start bit, then one sample per 16 ticks.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      rx_wr_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_wr_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (tick_16x) begin
            if (s_q == TICK_CNT_W'(MID_START)) begin
              s_q <= '0;
              if (!sync2_q) begin
                state_q <= DATA;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + TICK_CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tick_16x) begin
            if (s_q == TICK_CNT_W'(OVERSAMPLE - 1)) begin
              s_q     <= '0;
              shift_q <= {sync2_q, shift_q[DATA_WIDTH-1:1]};
              if (n_q == NW'(DATA_WIDTH - 1)) state_q <= STOP;
              else                            n_q     <= n_q + NW'(1);
            end else begin
              s_q <= s_q + TICK_CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick_16x) begin
            if (s_q == TICK_CNT_W'(OVERSAMPLE - 1)) begin
              s_q     <= '0;
              state_q <= IDLE;
              if (sync2_q) rx_wr_q     <= 1'b1;
              else         frame_err_q <= 1'b1;
            end else begin
              s_q <= s_q + TICK_CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .wr_en_i   (rx_wr_q),
    .wr_data_i (shift_q),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path: baud timing, frame reception, glitch/framing errors, FIFO limits, reset.
module tb_uart_rx_path;
  import uart_pkg::*;

  localparam int unsigned DIV_WIDTH  = 20;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned CPB        = 64;

  logic                   pclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DIV_WIDTH-1:0]   divisor;
  logic                   rx_i = 1'b1;
  logic                   rd_en = 1'b0;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   empty, full, tick_16x, frame_err, overrun;
  logic [$clog2(DEPTH):0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  uart_rx_path #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .divisor   (divisor),
    .rx_i      (rx_i),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .tick_16x  (tick_16x),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 8N1 frame at CPB cycles per bit; a bad stop is held low for 3/4 of the bit.
  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    rx_i = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      step(CPB);
    end
    if (good_stop) begin
      rx_i = 1'b1;
      step(CPB);
    end else begin
      rx_i = 1'b0;
      step(48);
      rx_i = 1'b1;
      step(16);
    end
    rx_i = 1'b1;
    step(32);
  endtask

  initial begin
    int early;
    int fe0;
    int ov0;
    int w;

    divisor = DIV_WIDTH'(DEFAULT_DIVISOR);
    step(3);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_tick",      32'(tick_16x),  32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);

    // Baud: after edge k the counter holds k, so the tick is high after edge 324.
    rst_n = 1'b1;
    early = 0;
    for (int k = 1; k <= 323; k++) begin
      step();
      if (tick_16x) early++;
    end
    check("baud_no_early_tick", 32'(early), 32'd0);
    step();
    check("baud_tick_first", 32'(tick_16x), 32'd1);
    step();
    check("baud_tick_single", 32'(tick_16x), 32'd0);
    step(323);
    check("baud_tick_before_second", 32'(tick_16x), 32'd0);
    step();
    check("baud_tick_second", 32'(tick_16x), 32'd1);

    // Clean frame 0xA5.
    divisor = DIV_WIDTH'(4);
    step(20);
    send_frame(8'hA5, 1'b1);
    check("a5_empty",   32'(empty),   32'd0);
    check("a5_rd_data", 32'(rd_data), 32'hA5);
    check("a5_count",   32'(count),   32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("a5_pop_empty", 32'(empty), 32'd1);
    check("a5_pop_count", 32'(count), 32'd0);

    // Short glitch on idle line is rejected at mid start bit.
    fe0 = fe_cnt;
    rx_i = 1'b0;
    step(3);
    rx_i = 1'b1;
    step(200);
    check("glitch_empty", 32'(empty),   32'd1);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_no_fe", 32'(fe_cnt),  32'(fe0));

    // Framing error on 0x3C.
    send_frame(8'h3C, 1'b0);
    step(100);
    check("fe_pulse_count", 32'(fe_cnt), 32'(fe0 + 1));
    check("fe_count",       32'(count),  32'd0);
    check("fe_empty",       32'(empty),  32'd1);
    check("fe_state",       32'(dut.state_q), 32'(IDLE));

    // 17 frames without reading: 16 stored, the 17th overruns.
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    check("fill_full",  32'(full),   32'd1);
    check("fill_count", 32'(count),  32'd16);
    check("fill_no_ov", 32'(ov_cnt), 32'(ov0));
    send_frame(8'h10, 1'b1);
    check("ovr_pulse", 32'(ov_cnt), 32'(ov0 + 1));
    check("ovr_count", 32'(count),  32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Full FIFO: pop on the same edge as an incoming write; only the pop lands.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
    check("refill_count", 32'(count), 32'd16);
    ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        w = 0;
        while (dut.rx_wr_q !== 1'b1 && w < 800) begin
          step();
          w++;
        end
        check("simul_strobe_seen", (w < 800) ? 32'd1 : 32'd0, 32'd1);
        if (w < 800) begin
          rd_en = 1'b1;
          step();
          rd_en = 1'b0;
          check("simul_count",   32'(count),   32'd15);
          check("simul_overrun", 32'(overrun), 32'd1);
          check("simul_head",    32'(rd_data), 32'h21);
        end
      end
    join
    check("simul_ov_total", 32'(ov_cnt), 32'(ov0 + 1));
    check("simul_count_after", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("drain2_%0d", i), 32'(rd_data), 32'(8'h21 + i));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    check("drain2_empty", 32'(empty), 32'd1);

    // Reset mid-frame clears the FIFO and discards the partial byte.
    send_frame(8'h11, 1'b1);
    check("pre_rst_count", 32'(count), 32'd1);
    rx_i = 1'b0;
    step(CPB);
    rx_i = 1'b1;
    step(CPB);
    rx_i = 1'b0;
    step(CPB);
    rx_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_empty",   32'(empty),   32'd1);
    check("midrst_count",   32'(count),   32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    step(5);
    rst_n = 1'b1;
    step(700);
    check("postrst_empty", 32'(empty), 32'd1);
    check("postrst_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h96, 1'b1);
    check("postrst_rd_data", 32'(rd_data), 32'h96);
    check("postrst_count",   32'(count),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
